// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among NUM_REQ requesters.
// The mux is combinational and adds no latency. Registered grant state keeps the
// selected channel stable while the sink stalls.
// Optional feature: define STREAM_ARB_PKT_LOCK_EN to lock the grant until m_last.
module stream_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  output logic                          m_last,
  output logic [IDX_W-1:0]              m_sel,
  input  logic                          m_ready
);

  typedef enum logic [1:0] {StIdle, StHold, StPkt} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] act_idx;
  logic             act_en;
  logic             act_valid;
  logic             act_last;
  logic [DATA_WIDTH-1:0] act_data;
  logic             hs;

  // Index after idx, wrapping explicitly so non-power-of-2 counts never overrun.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Winner search: first valid channel starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && s_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  // Active channel: live winner while idle, registered grant otherwise.
  always_comb begin
    act_idx   = (state_q == StIdle) ? win_idx : gnt_q;
    act_en    = (state_q != StIdle) || win_found;
    act_valid = 1'b0;
    act_last  = 1'b0;
    act_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (act_idx == IDX_W'(i)) begin
        act_valid = s_valid[i];
        act_last  = s_last[i];
        act_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output mux; rst_n gates every output directly so nothing leaks during reset.
  always_comb begin
    m_valid = rst_n & act_en & act_valid;
    m_last  = rst_n & act_last;
    m_data  = rst_n ? act_data : '0;
    m_sel   = rst_n ? act_idx : '0;
    s_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      s_ready[i] = rst_n & act_en & m_ready & (act_idx == IDX_W'(i));
    end
    hs = m_valid & m_ready;
  end

  // Next-state logic for grant locking and round-robin pointer advance.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
`ifdef STREAM_ARB_PKT_LOCK_EN
          if (!act_last) begin
            state_d = StPkt;
            gnt_d   = act_idx;
          end else begin
            rr_ptr_d = next_idx(act_idx);
          end
`else
          rr_ptr_d = next_idx(act_idx);
`endif
        end else if (win_found) begin
          // Lock the stalled winner so a later higher-priority valid cannot steal it.
          state_d = StHold;
          gnt_d   = win_idx;
        end
      end
      StHold: begin
        if (hs) begin
`ifdef STREAM_ARB_PKT_LOCK_EN
          if (!act_last) begin
            state_d = StPkt;
          end else begin
            state_d  = StIdle;
            rr_ptr_d = next_idx(gnt_q);
          end
`else
          state_d  = StIdle;
          rr_ptr_d = next_idx(gnt_q);
`endif
        end else if (!act_valid) begin
          // Producer withdrew valid: release without advancing the pointer.
          state_d = StIdle;
        end
      end
      StPkt: begin
`ifdef STREAM_ARB_PKT_LOCK_EN
        // Gaps in valid keep the grant; only the last beat releases it.
        if (hs && act_last) begin
          state_d  = StIdle;
          rr_ptr_d = next_idx(gnt_q);
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
